// File: rtl/mio_bus_arbiter.sv
// Round-robin arbiter sharing one memory/IO port between the CPU and a DMA master.
// Each grant runs a fixed WAIT_CYCLES access followed by a one-cycle ready pulse.
module mio_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_ready_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_ready_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              gnt_dma_o,
  output logic              busy_o
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              lastGrant_q, lastGrant_d;
  logic              gntDma_q, gntDma_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpuRdata_q, cpuRdata_d;
  logic [DATA_W-1:0] dmaRdata_q, dmaRdata_d;
  logic              pickDma;

  // lastGrant resets to DMA so the first contest goes to the CPU, while the
  // visible gnt_dma status still comes out of reset as 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      lastGrant_q <= 1'b1;
      gntDma_q    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpuRdata_q  <= '0;
      dmaRdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lastGrant_q <= lastGrant_d;
      gntDma_q    <= gntDma_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpuRdata_q  <= cpuRdata_d;
      dmaRdata_q  <= dmaRdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lastGrant_d = lastGrant_q;
    gntDma_d    = gntDma_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpuRdata_d  = cpuRdata_q;
    dmaRdata_d  = dmaRdata_q;
    pickDma     = dma_req_i && (!cpu_req_i || !lastGrant_q);

    case (state_q)
      IDLE: begin
        if (cpu_req_i || dma_req_i) begin
          state_d     = ACCESS;
          cnt_d       = CNT_LOAD;
          lastGrant_d = pickDma;
          gntDma_d    = pickDma;
          we_d        = pickDma ? dma_we_i    : cpu_we_i;
          addr_d      = pickDma ? dma_addr_i  : cpu_addr_i;
          wdata_d     = pickDma ? dma_wdata_i : cpu_wdata_i;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!we_q) begin
            if (gntDma_q) dmaRdata_d = mem_rdata_i;
            else          cpuRdata_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address and write data stay on the bus from the latched regs between accesses.
  assign mem_en_o    = (state_q == ACCESS);
  assign mem_we_o    = (state_q == ACCESS) && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_ready_o = (state_q == DONE) && !gntDma_q;
  assign dma_ready_o = (state_q == DONE) && gntDma_q;
  assign cpu_rdata_o = cpuRdata_q;
  assign dma_rdata_o = dmaRdata_q;
  assign gnt_dma_o   = gntDma_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter: single-master vector table plus
// round-robin, back-to-back and mid-access reset sequences.
module tb_mio_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          cpu_ready, dma_ready, mem_en, mem_we, gnt_dma, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_ready_o(cpu_ready),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
    .dma_wdata_i(dma_wdata), .dma_rdata_o(dma_rdata), .dma_ready_o(dma_ready),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .gnt_dma_o(gnt_dma), .busy_o(busy)
  );

  typedef struct {
    logic        isDma;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memRdata;
    logic        dropEarly;
    logic [31:0] expCpuRdata;
    logic [31:0] expDmaRdata;
  } vec_t;

  vec_t vecs[6];

  int   readyCount, burstCount, dmaReadyCount, lateReady;
  int   readyCyc[4];
  int   burstCyc[4];
  logic readyWho[4];
  logic burstGnt[4];
  logic prevEn;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    checkOutput({tag, "_dma_rdata"}, dma_rdata, 32'h0);
    checkOutput({tag, "_cpu_ready"}, 32'(cpu_ready), 32'h0);
    checkOutput({tag, "_dma_ready"}, 32'(dma_ready), 32'h0);
    checkOutput({tag, "_mem_en"}, 32'(mem_en), 32'h0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    checkOutput({tag, "_gnt_dma"}, 32'(gnt_dma), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk); #1;
    if (v.isDma) begin
      dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    mem_rdata = v.memRdata;
    for (int i = 0; i < WC; i++) begin
      @(posedge clk); #1;
      if (v.dropEarly) begin
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
      checkOutput("acc_mem_en", 32'(mem_en), 32'h1);
      checkOutput("acc_mem_we", 32'(mem_we), 32'(v.we));
      checkOutput("acc_mem_addr", mem_addr, v.addr);
      checkOutput("acc_mem_wdata", mem_wdata, v.wdata);
      checkOutput("acc_gnt_dma", 32'(gnt_dma), 32'(v.isDma));
      checkOutput("acc_cpu_ready", 32'(cpu_ready), 32'h0);
      checkOutput("acc_dma_ready", 32'(dma_ready), 32'h0);
      checkOutput("acc_busy", 32'(busy), 32'h1);
    end
    @(posedge clk); #1;
    checkOutput("done_mem_en", 32'(mem_en), 32'h0);
    checkOutput("done_mem_we", 32'(mem_we), 32'h0);
    checkOutput("done_mem_addr", mem_addr, v.addr);
    checkOutput("done_cpu_ready", 32'(cpu_ready), 32'(!v.isDma));
    checkOutput("done_dma_ready", 32'(dma_ready), 32'(v.isDma));
    checkOutput("done_cpu_rdata", cpu_rdata, v.expCpuRdata);
    checkOutput("done_dma_rdata", dma_rdata, v.expDmaRdata);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_busy", 32'(busy), 32'h0);
    checkOutput("idle_cpu_ready", 32'(cpu_ready), 32'h0);
    checkOutput("idle_dma_ready", 32'(dma_ready), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //          isDma we   addr           wdata          memRdata       drop  expCpu         expDma
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'h0000_0001, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h8765_4321, 1'b0, 32'h0000_0001, 32'h8765_4321};

    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0;
    #12;
    checkAllZero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Round robin: both masters request straight out of reset.
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200;
    mem_rdata = 32'h0BAD_F00D;
    readyCount = 0; burstCount = 0; prevEn = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 40 && readyCount < 4; cyc++) begin
      @(posedge clk); #1;
      checkOutput("rr_ready_excl", 32'(cpu_ready & dma_ready), 32'h0);
      if (mem_en && !prevEn && burstCount < 4) begin
        burstGnt[burstCount] = gnt_dma;
        burstCount++;
      end
      prevEn = mem_en;
      if (cpu_ready || dma_ready) begin
        readyWho[readyCount] = dma_ready;
        readyCyc[readyCount] = cyc;
        readyCount++;
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    checkOutput("rr_ready_count", 32'(readyCount), 32'd4);
    checkOutput("rr_burst_count", 32'(burstCount), 32'd4);
    for (int i = 0; i < readyCount; i++)
      checkOutput("rr_ready_who", 32'(readyWho[i]), 32'(i % 2));
    for (int i = 0; i < burstCount; i++)
      checkOutput("rr_burst_gnt", 32'(burstGnt[i]), 32'(i % 2));
    for (int i = 1; i < readyCount; i++)
      checkOutput("rr_ready_spacing", 32'(readyCyc[i] - readyCyc[i-1]), 32'(WC + 2));
    checkOutput("rr_cpu_rdata", cpu_rdata, 32'h0BAD_F00D);
    checkOutput("rr_dma_rdata", dma_rdata, 32'h0BAD_F00D);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back CPU reads with the request held high.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
    mem_rdata = 32'h5A5A_0001;
    readyCount = 0; burstCount = 0; dmaReadyCount = 0; prevEn = 1'b0;
    for (int cyc = 0; cyc < 40 && readyCount < 3; cyc++) begin
      @(posedge clk); #1;
      if (dma_ready) dmaReadyCount++;
      if (mem_en && !prevEn && burstCount < 4) begin
        burstGnt[burstCount] = gnt_dma;
        burstCyc[burstCount] = cyc;
        burstCount++;
      end
      prevEn = mem_en;
      if (cpu_ready) begin
        checkOutput("b2b_cpu_rdata", cpu_rdata, 32'h5A5A_0001);
        readyCount++;
      end
    end
    cpu_req = 1'b0;
    checkOutput("b2b_ready_count", 32'(readyCount), 32'd3);
    checkOutput("b2b_dma_ready", 32'(dmaReadyCount), 32'd0);
    checkOutput("b2b_burst_count", 32'(burstCount), 32'd3);
    for (int i = 0; i < burstCount; i++)
      checkOutput("b2b_burst_gnt", 32'(burstGnt[i]), 32'h0);
    for (int i = 1; i < burstCount; i++)
      checkOutput("b2b_burst_spacing", 32'(burstCyc[i] - burstCyc[i-1]), 32'(WC + 2));
    repeat (2) @(posedge clk);
    #1;

    // Reset asserted in the middle of an access.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h400; cpu_wdata = 32'h7777_7777;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("mid_mem_en_before", 32'(mem_en), 32'h1);
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    checkAllZero("midreset");
    #2;
    rst_n = 1'b1;
    lateReady = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk); #1;
      if (cpu_ready || dma_ready || busy) lateReady++;
    end
    checkOutput("midreset_no_ready", 32'(lateReady), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
